// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: opcode constants,
// the sequencer state type and the status-bit positions [C V Z N].
package alu_seq_pkg;

    localparam int STATUS_W = 4;

    // Status bit positions inside alu_status / rsp_status
    localparam int STAT_C = 3;
    localparam int STAT_V = 2;
    localparam int STAT_Z = 1;
    localparam int STAT_N = 0;

    // ALU opcodes
    localparam logic [3:0] OP_NOT   = 4'b0000;
    localparam logic [3:0] OP_NAND  = 4'b0001;
    localparam logic [3:0] OP_NOR   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0101;
    localparam logic [3:0] OP_AND   = 4'b0110;
    localparam logic [3:0] OP_OR    = 4'b0111;
    localparam logic [3:0] OP_RIGHT = 4'b1000;
    localparam logic [3:0] OP_ARTH  = 4'b1001;
    localparam logic [3:0] OP_XNOR  = 4'b1100;
    localparam logic [3:0] OP_INC   = 4'b1101;
    localparam logic [3:0] OP_DEC   = 4'b1110;
    localparam logic [3:0] OP_LEFT  = 4'b1111;

    // The two encodings the ALU does not implement
    localparam logic [3:0] OP_ILL_A = 4'b1010;
    localparam logic [3:0] OP_ILL_B = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    function automatic logic is_illegal(input logic [3:0] op);
        return (op == OP_ILL_A) || (op == OP_ILL_B);
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Bundle of the command, ALU and response signals of the sequencer.
// master = the sequencer itself, slave = the surrounding system.
interface alu_cmd_sequencer_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;

    logic [7:0]  alu_oparand1;
    logic [7:0]  alu_oparand2;
    logic [3:0]  alu_opcode;
    logic        alu_enable;
    logic [15:0] alu_result;
    logic [3:0]  alu_status;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [3:0]  rsp_status;
    logic [3:0]  rsp_opcode;
    logic        rsp_illegal;

    logic [3:0]  sticky_status;
    logic        sticky_clr;
    logic        busy;

    modport master (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b,
        input  alu_result, alu_status,
        input  rsp_ready, sticky_clr,
        output cmd_ready,
        output alu_oparand1, alu_oparand2, alu_opcode, alu_enable,
        output rsp_valid, rsp_result, rsp_status, rsp_opcode, rsp_illegal,
        output sticky_status, busy
    );

    modport slave (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b,
        output alu_result, alu_status,
        output rsp_ready, sticky_clr,
        input  cmd_ready,
        input  alu_oparand1, alu_oparand2, alu_opcode, alu_enable,
        input  rsp_valid, rsp_result, rsp_status, rsp_opcode, rsp_illegal,
        input  sticky_status, busy
    );

endinterface

// File: rtl/alu_seq_sticky.sv
// Sticky status accumulator: ORs in the status of every legal capture.
// A clear coinciding with a capture leaves only the new status.
module alu_seq_sticky
    import alu_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                capture,
    input  logic                clr,
    input  logic [STATUS_W-1:0] status,
    output logic [STATUS_W-1:0] sticky
);

    logic [STATUS_W-1:0] sticky_reg;

    // Clear-then-OR on capture; a lone clear empties the register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_reg <= '0;
        end else if (capture) begin
            sticky_reg <= (clr ? '0 : sticky_reg) | status;
        end else if (clr) begin
            sticky_reg <= '0;
        end
    end

    assign sticky = sticky_reg;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// ALU command sequencer: accepts one command, drives the ALU for
// WAIT_CYCLES cycles (1..15), captures result/status and holds the
// response until it is taken. Illegal opcodes never enable the ALU and
// answer one cycle after acceptance with a zero result.
// Optional feature: define ALU_SEQ_STICKY_FLAGS_EN to accumulate
// captured status bits in sticky_status (cleared by sticky_clr).
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    alu_cmd_sequencer_if.master io
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic        illegal_reg;
    logic        cmd_ready_reg;
    logic        busy_reg;
    logic        alu_enable_reg;
    logic [7:0]  oparand1_reg;
    logic [7:0]  oparand2_reg;
    logic [3:0]  opcode_reg;
    logic        rsp_valid_reg;
    logic [15:0] rsp_result_reg;
    logic [3:0]  rsp_status_reg;
    logic [3:0]  rsp_opcode_reg;
    logic        rsp_illegal_reg;

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            illegal_reg     <= 1'b0;
            cmd_ready_reg   <= 1'b1;
            busy_reg        <= 1'b0;
            alu_enable_reg  <= 1'b0;
            oparand1_reg    <= '0;
            oparand2_reg    <= '0;
            opcode_reg      <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_result_reg  <= '0;
            rsp_status_reg  <= '0;
            rsp_opcode_reg  <= '0;
            rsp_illegal_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (io.cmd_valid) begin
                        oparand1_reg   <= io.cmd_a;
                        oparand2_reg   <= io.cmd_b;
                        opcode_reg     <= io.cmd_opcode;
                        illegal_reg    <= is_illegal(io.cmd_opcode);
                        // Illegal commands wait one cycle with the ALU idle
                        alu_enable_reg <= !is_illegal(io.cmd_opcode);
                        cnt_reg        <= is_illegal(io.cmd_opcode) ? 4'd0 : CNT_LOAD;
                        cmd_ready_reg  <= 1'b0;
                        busy_reg       <= 1'b1;
                        state_reg      <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_reg == 4'd0) begin
                        alu_enable_reg  <= 1'b0;
                        rsp_valid_reg   <= 1'b1;
                        rsp_result_reg  <= illegal_reg ? 16'd0 : io.alu_result;
                        rsp_status_reg  <= illegal_reg ? 4'd0 : io.alu_status;
                        rsp_opcode_reg  <= opcode_reg;
                        rsp_illegal_reg <= illegal_reg;
                        state_reg       <= ST_RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                ST_RESP: begin
                    // Returning to IDLE here means acceptance is one cycle later
                    if (io.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        cmd_ready_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign io.cmd_ready    = cmd_ready_reg;
    assign io.busy         = busy_reg;
    assign io.alu_enable   = alu_enable_reg;
    assign io.alu_oparand1 = oparand1_reg;
    assign io.alu_oparand2 = oparand2_reg;
    assign io.alu_opcode   = opcode_reg;
    assign io.rsp_valid    = rsp_valid_reg;
    assign io.rsp_result   = rsp_result_reg;
    assign io.rsp_status   = rsp_status_reg;
    assign io.rsp_opcode   = rsp_opcode_reg;
    assign io.rsp_illegal  = rsp_illegal_reg;

`ifdef ALU_SEQ_STICKY_FLAGS_EN
    logic                capture;
    logic [STATUS_W-1:0] sticky;

    assign capture = (state_reg == ST_DRIVE) && (cnt_reg == 4'd0) && !illegal_reg;

    alu_seq_sticky u_sticky (
        .clk     (clk),
        .rst     (rst),
        .capture (capture),
        .clr     (io.sticky_clr),
        .status  (io.alu_status),
        .sticky  (sticky)
    );

    assign io.sticky_status = sticky;
`else
    logic unused_sticky_clr;

    assign unused_sticky_clr = io.sticky_clr;
    assign io.sticky_status  = '0;
`endif

endmodule
